// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic intersection controller.
//   state_t    : controller states
//   DEF_*      : default durations and sizes used as parameter defaults
//   next_phase : advance the served approach index modulo the approach count
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_FLASH
    } state_t;

    localparam int DEF_N_DIR      = 2;
    localparam int DEF_GREEN      = 7;
    localparam int DEF_YELLOW     = 3;
    localparam int DEF_ALL_RED    = 2;
    localparam int DEF_PED_EXT    = 4;
    localparam int DEF_FLASH_HALF = 2;
    localparam int DEF_CNT_W      = 8;

    function automatic logic [1:0] next_phase(input logic [1:0] phase,
                                              input int unsigned n_dir);
        if (32'(phase) >= n_dir - 1) begin
            return 2'd0;
        end
        return phase + 2'd1;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable down-counter used to time each controller state.
//   clk        : clock, rising edge
//   i_rst      : synchronous active-high reset, loads RST_VAL
//   i_load     : load i_load_val this edge (takes priority over counting)
//   i_load_val : value to load
//   o_zero     : counter currently reads zero
// The counter holds at zero rather than wrapping.
module phase_timer #(
    parameter int                CNT_W   = 8,
    parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule

// File: rtl/traffic_intersection.sv
// Traffic intersection controller: cycles green/yellow/all-red over N_DIR
// approaches, extends green for pending pedestrian requests and supports a
// flashing-yellow maintenance mode entered at the end of all-red.
//   clk, i_rst  : clock and synchronous active-high reset
//   i_ped_req   : per-approach pedestrian request
//   i_flash     : flashing-yellow mode request
//   o_red/o_yellow/o_green/o_walk : registered lamp outputs per approach
//   o_phase     : approach currently served
//   o_ped_pend  : latched pending pedestrian requests
module traffic_intersection
    import traffic_pkg::*;
#(
    parameter int N_DIR      = DEF_N_DIR,
    parameter int GREEN      = DEF_GREEN,
    parameter int YELLOW     = DEF_YELLOW,
    parameter int ALL_RED    = DEF_ALL_RED,
    parameter int PED_EXT    = DEF_PED_EXT,
    parameter int FLASH_HALF = DEF_FLASH_HALF,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic [N_DIR-1:0] i_ped_req,
    input  logic             i_flash,
    output logic [N_DIR-1:0] o_red,
    output logic [N_DIR-1:0] o_yellow,
    output logic [N_DIR-1:0] o_green,
    output logic [N_DIR-1:0] o_walk,
    output logic [1:0]       o_phase,
    output logic [N_DIR-1:0] o_ped_pend
);

    if (N_DIR < 2 || N_DIR > 4 ||
        GREEN < 1 || GREEN + PED_EXT >= 2**CNT_W || PED_EXT < 0 ||
        YELLOW < 1 || YELLOW >= 2**CNT_W ||
        ALL_RED < 1 || ALL_RED >= 2**CNT_W ||
        FLASH_HALF < 1 || FLASH_HALF >= 2**CNT_W) begin : g_param_err
        $error("traffic_intersection: parameter out of range");
    end

    localparam logic [CNT_W-1:0] LD_GREEN     = CNT_W'(GREEN - 1);
    localparam logic [CNT_W-1:0] LD_GREEN_PED = CNT_W'(GREEN + PED_EXT - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW    = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED   = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] LD_FLASH     = CNT_W'(FLASH_HALF - 1);
    localparam logic [N_DIR-1:0] ONE          = N_DIR'(1);

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [N_DIR-1:0] pend_q, pend_d;
    logic             flash_on_q, flash_on_d;
    logic             ped_green_q, ped_green_d;
    logic [N_DIR-1:0] red_q, red_d, yellow_q, yellow_d;
    logic [N_DIR-1:0] green_q, green_d, walk_q, walk_d;
    logic [N_DIR-1:0] sel_q, sel_d;
    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_ALL_RED)
    ) u_timer (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_zero     (tmr_zero)
    );

    assign sel_q = ONE << phase_q;
    assign sel_d = ONE << phase_d;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        flash_on_d  = flash_on_q;
        ped_green_d = ped_green_q;
        pend_d      = pend_q | i_ped_req;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        unique case (state_q)
            ST_ALLRED: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (i_flash) begin
                        state_d    = ST_FLASH;
                        tmr_val    = LD_FLASH;
                        flash_on_d = 1'b1;
                    end else begin
                        // A request sampled on the entry edge is served too.
                        state_d     = ST_GREEN;
                        ped_green_d = |(pend_d & sel_q);
                        pend_d      = pend_d & ~sel_q;
                        tmr_val     = ped_green_d ? LD_GREEN_PED : LD_GREEN;
                    end
                end
            end
            ST_GREEN: begin
                if (tmr_zero) begin
                    state_d     = ST_YELLOW;
                    tmr_load    = 1'b1;
                    tmr_val     = LD_YELLOW;
                    ped_green_d = 1'b0;
                end
            end
            ST_YELLOW: begin
                if (tmr_zero) begin
                    state_d  = ST_ALLRED;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ALL_RED;
                    phase_d  = next_phase(phase_q, unsigned'(N_DIR));
                end
            end
            ST_FLASH: begin
                if (!i_flash) begin
                    state_d    = ST_ALLRED;
                    phase_d    = 2'd0;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_ALL_RED;
                    flash_on_d = 1'b0;
                end else if (tmr_zero) begin
                    flash_on_d = ~flash_on_q;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_FLASH;
                end
            end
            default: state_d = ST_ALLRED;
        endcase
    end

    // Lamps decode from next-state values so they change on the same edge
    // as the state and can be held in flops.
    always_comb begin
        red_d    = '0;
        yellow_d = '0;
        green_d  = '0;
        walk_d   = '0;
        case (state_d)
            ST_ALLRED: red_d = '1;
            ST_GREEN: begin
                red_d   = ~sel_d;
                green_d = sel_d;
                if (ped_green_d) begin
                    walk_d = sel_d;
                end
            end
            ST_YELLOW: begin
                red_d    = ~sel_d;
                yellow_d = sel_d;
            end
            ST_FLASH: yellow_d = {N_DIR{flash_on_d}};
            default: red_d = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_ALLRED;
            phase_q     <= 2'd0;
            pend_q      <= '0;
            flash_on_q  <= 1'b0;
            ped_green_q <= 1'b0;
            red_q       <= '1;
            yellow_q    <= '0;
            green_q     <= '0;
            walk_q      <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            flash_on_q  <= flash_on_d;
            ped_green_q <= ped_green_d;
            red_q       <= red_d;
            yellow_q    <= yellow_d;
            green_q     <= green_d;
            walk_q      <= walk_d;
        end
    end

    assign o_red      = red_q;
    assign o_yellow   = yellow_q;
    assign o_green    = green_q;
    assign o_walk     = walk_q;
    assign o_phase    = phase_q;
    assign o_ped_pend = pend_q;

endmodule

// File: tb/tb_traffic_intersection.sv
// Randomized scoreboard bench: two controllers (2 and 4 approaches) driven
// with random pedestrian, flash and reset activity. A segment-level reference
// model predicts each cycle's outputs into per-instance queues; a monitor pops
// and compares after every clock edge and checks lamp exclusivity.
module tb_traffic_intersection;

    localparam int GREEN      = 7;
    localparam int YELLOW     = 3;
    localparam int ALL_RED    = 2;
    localparam int PED_EXT    = 4;
    localparam int FLASH_HALF = 2;
    localparam int NCYC       = 4000;

    // Segment kinds of the reference model.
    localparam int K_AR = 0;
    localparam int K_G  = 1;
    localparam int K_Y  = 2;
    localparam int K_FL = 3;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] yel;
        logic [3:0] grn;
        logic [3:0] walk;
        logic [1:0] phase;
        logic [3:0] pend;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req2;
    logic [3:0] req4;
    logic       flash2, flash4;
    logic [1:0] r2, y2, g2, w2, ph2, pp2;
    logic [3:0] r4, y4, g4, w4, pp4;
    logic [1:0] ph4;

    always #5 clk = ~clk;

    traffic_intersection dut2 (
        .clk(clk), .i_rst(rst), .i_ped_req(req2), .i_flash(flash2),
        .o_red(r2), .o_yellow(y2), .o_green(g2), .o_walk(w2),
        .o_phase(ph2), .o_ped_pend(pp2)
    );

    traffic_intersection #(.N_DIR(4)) dut4 (
        .clk(clk), .i_rst(rst), .i_ped_req(req4), .i_flash(flash4),
        .o_red(r4), .o_yellow(y4), .o_green(g4), .o_walk(w4),
        .o_phase(ph4), .o_ped_pend(pp4)
    );

    obs_t q2[$];
    obs_t q4[$];
    int   total = 0;
    int   bad   = 0;
    bit   started = 0;

    int         m_kind[2];
    int         m_left[2];
    int         m_phase[2];
    logic [3:0] m_pend[2];
    bit         m_walk[2];
    int         m_fc[2];
    int         m_n[2] = '{2, 4};

    task automatic model_step(input int i, input logic [3:0] req,
                              input bit fl, input bit r, output obs_t o);
        logic [3:0] all;
        logic [3:0] sel;
        logic [3:0] pn;
        all = 4'((1 << m_n[i]) - 1);
        if (r) begin
            m_kind[i]  = K_AR;
            m_left[i]  = ALL_RED;
            m_phase[i] = 0;
            m_pend[i]  = '0;
            m_walk[i]  = 0;
            m_fc[i]    = 0;
        end else begin
            sel = 4'(1 << m_phase[i]);
            pn  = m_pend[i] | (req & all);
            if (m_kind[i] == K_FL) begin
                if (!fl) begin
                    m_kind[i]  = K_AR;
                    m_left[i]  = ALL_RED;
                    m_phase[i] = 0;
                end else begin
                    m_fc[i]++;
                end
            end else if (m_left[i] > 1) begin
                m_left[i]--;
            end else begin
                case (m_kind[i])
                    K_AR: begin
                        if (fl) begin
                            m_kind[i] = K_FL;
                            m_fc[i]   = 0;
                        end else begin
                            m_kind[i] = K_G;
                            m_walk[i] = (pn & sel) != 0;
                            m_left[i] = GREEN + (m_walk[i] ? PED_EXT : 0);
                            pn        = pn & ~sel;
                        end
                    end
                    K_G: begin
                        m_kind[i] = K_Y;
                        m_left[i] = YELLOW;
                    end
                    default: begin
                        m_kind[i]  = K_AR;
                        m_left[i]  = ALL_RED;
                        m_phase[i] = (m_phase[i] + 1) % m_n[i];
                    end
                endcase
            end
            m_pend[i] = pn;
        end
        o   = '0;
        sel = 4'(1 << m_phase[i]);
        case (m_kind[i])
            K_AR: o.red = all;
            K_G: begin
                o.red  = all & ~sel;
                o.grn  = sel;
                o.walk = m_walk[i] ? sel : 4'd0;
            end
            K_Y: begin
                o.red = all & ~sel;
                o.yel = sel;
            end
            default: o.yel = (((m_fc[i] / FLASH_HALF) % 2) == 0) ? all : 4'd0;
        endcase
        o.phase = 2'(m_phase[i]);
        o.pend  = m_pend[i];
    endtask

    // Stimulus: inputs change on the falling edge; the expected response to
    // the following rising edge is pushed at the same time.
    initial begin
        obs_t e;
        rst    = 1'b1;
        req2   = '0;
        req4   = '0;
        flash2 = 1'b0;
        flash4 = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst = (cyc < 3) || ($urandom_range(0, 399) == 0);
            for (int b = 0; b < 4; b++) begin
                req4[b] = ($urandom_range(0, 9) == 0);
            end
            for (int b = 0; b < 2; b++) begin
                req2[b] = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 89) == 0) flash2 = ~flash2;
            if ($urandom_range(0, 89) == 0) flash4 = ~flash4;
            model_step(0, {2'b00, req2}, flash2, rst, e);
            q2.push_back(e);
            model_step(1, req4, flash4, rst, e);
            q4.push_back(e);
            started = 1;
        end
        @(posedge clk);
        #3;
        total++;
        if (q2.size() != 0 || q4.size() != 0) begin
            bad++;
            $display("FAIL drain: left q2=%0d q4=%0d required 0", q2.size(), q4.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: outputs are valid every cycle; sample 2 time units after the edge.
    initial begin
        obs_t a;
        obs_t e;
        int   lamps;
        int   lit;
        bit   ok;
        forever begin
            @(posedge clk);
            #2;
            a = '{red: {2'b00, r2}, yel: {2'b00, y2}, grn: {2'b00, g2},
                  walk: {2'b00, w2}, phase: ph2, pend: {2'b00, pp2}};
            if (q2.size() > 0) begin
                e = q2.pop_front();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL n2 t=%0t got=%h required=%h", $time, a, e);
                end
            end else if (started) begin
                total++;
                bad++;
                $display("FAIL n2 underflow t=%0t got=%h required=queued entry", $time, a);
            end

            a = '{red: r4, yel: y4, grn: g4, walk: w4, phase: ph4, pend: pp4};
            if (q4.size() > 0) begin
                e = q4.pop_front();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL n4 t=%0t got=%h required=%h", $time, a, e);
                end
            end else if (started) begin
                total++;
                bad++;
                $display("FAIL n4 underflow t=%0t got=%h required=queued entry", $time, a);
            end

            // One lamp at most per approach; only one non-red approach unless
            // every approach is in flash (no red, no green, no walk).
            ok  = 1;
            lit = 0;
            for (int k = 0; k < 4; k++) begin
                lamps = int'(r4[k]) + int'(y4[k]) + int'(g4[k]);
                if (lamps > 1) ok = 0;
                if (g4[k] || y4[k]) lit++;
            end
            if (lit > 1 && !(r4 == 4'd0 && g4 == 4'd0 && w4 == 4'd0)) ok = 0;
            total++;
            assert (ok) else begin
                bad++;
                $display("FAIL excl4 t=%0t got r=%b y=%b g=%b required exclusive lamps",
                         $time, r4, y4, g4);
            end
        end
    end

endmodule
